// File: rtl/ab_testing.sv
// Fixed-length xorshift128 engine: captures a seed during reset, runs N_ITER steps, then holds.
// Optional ABT_ZERO_GUARD_EN: an all-zero seed is replaced by the standard xorshift128 constants.
module ab_testing #(
  parameter int unsigned N_ITER = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] S,
  output logic [127:0] outS,
  output logic         finish
);

  typedef enum logic [1:0] {
    StLoad,
    StRun,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] NIterC = CNT_W'(N_ITER);

  state_e             state_q, state_d;
  logic [31:0]        x_q, y_q, z_q, w_q;
  logic [31:0]        x_d, y_d, z_d, w_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       outs_q, outs_d;
  logic               finish_q, finish_d;

  logic [31:0]        seed_x, seed_y, seed_z, seed_w;
  logic [31:0]        step_t, step_w;

  always_comb begin
`ifdef ABT_ZERO_GUARD_EN
    // An all-zero state is a fixed point of xorshift; substitute a known-good seed.
    if (S == '0) begin
      seed_x = 32'h075BCD15;
      seed_y = 32'h159A55E5;
      seed_z = 32'h1F123BB5;
      seed_w = 32'h05491333;
    end else begin
      seed_x = S[31:0];
      seed_y = S[63:32];
      seed_z = S[95:64];
      seed_w = S[127:96];
    end
`else
    seed_x = S[31:0];
    seed_y = S[63:32];
    seed_z = S[95:64];
    seed_w = S[127:96];
`endif
  end

  always_comb begin
    step_t = x_q ^ (x_q << 11);
    step_w = w_q ^ (w_q >> 19) ^ step_t ^ (step_t >> 8);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    w_d      = w_q;
    cnt_d    = cnt_q;
    outs_d   = outs_q;
    finish_d = finish_q;

    unique case (state_q)
      StLoad: begin
        // Release edge already performs step 1.
        state_d = StRun;
        x_d     = y_q;
        y_d     = z_q;
        z_d     = w_q;
        w_d     = step_w;
        cnt_d   = CNT_W'(1);
      end
      StRun: begin
        if (cnt_q == NIterC) begin
          state_d  = StDone;
          outs_d   = {w_q, z_q, y_q, x_q};
          finish_d = 1'b1;
        end else begin
          x_d   = y_q;
          y_d   = z_q;
          z_d   = w_q;
          w_d   = step_w;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StLoad;
      x_q      <= seed_x;
      y_q      <= seed_y;
      z_q      <= seed_z;
      w_q      <= seed_w;
      cnt_q    <= '0;
      outs_q   <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      w_q      <= w_d;
      cnt_q    <= cnt_d;
      outs_q   <= outs_d;
      finish_q <= finish_d;
    end
  end

  assign outS   = outs_q;
  assign finish = finish_q;

endmodule

// File: tb/tb_ab_testing.sv
// Directed bench for ab_testing: three instances (N_ITER = 1, 4, 8) share clock, reset and seed.
module tb_ab_testing;

  logic         clk;
  logic         rst;
  logic [127:0] S;
  logic [127:0] outs1, outs4, outs8;
  logic         fin1, fin4, fin8;

  int n_cmp = 0;
  int n_err = 0;

  ab_testing #(.N_ITER(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .S(S), .outS(outs1), .finish(fin1)
  );
  ab_testing #(.N_ITER(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .S(S), .outS(outs4), .finish(fin4)
  );
  ab_testing u_dut (
    .clk(clk), .rst(rst), .S(S), .outS(outs8), .finish(fin8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference xorshift128, written straight from the recurrence.
  function automatic logic [127:0] xs_ref(input logic [127:0] s, input int n);
    logic [31:0] x, y, z, w, t;
    {w, z, y, x} = s;
    for (int i = 0; i < n; i++) begin
      t = x ^ (x << 11);
      x = y;
      y = z;
      z = w;
      w = w ^ (w >> 19) ^ t ^ (t >> 8);
    end
    return {w, z, y, x};
  endfunction

  // Reset for two edges, release, and check the 8-step instance edge by edge.
  task automatic run8(input string tag, input logic [127:0] seed, input logic [127:0] exp);
    rst = 1'b0;
    S   = seed;
    tick();
    check_eq({tag, "_rst_fin"}, 128'(fin8), 128'(0));
    check_eq({tag, "_rst_out"}, outs8, '0);
    tick();
    rst = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check_eq({tag, "_fin"}, 128'(fin8), 128'(e == 9));
    end
    check_eq({tag, "_out"}, outs8, exp);
  endtask

  logic [127:0] exp_zero;
  logic [127:0] held;

  initial begin
    rst = 1'b0;
    S   = {32'h0, 32'h0, 32'h0, 32'h1};
    tick();
    tick();
    check_eq("reset_fin", 128'(fin8), 128'(0));
    check_eq("reset_out", outs8, '0);

    // Hand-computed: step 1 of x=1 gives w=0x809, which then propagates through z, y, x.
    rst = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_eq("n4_fin", 128'(fin4), 128'(e == 5));
      if (e == 1) check_eq("n1_fin_e1", 128'(fin1), 128'(0));
      if (e == 2) begin
        check_eq("n1_fin", 128'(fin1), 128'(1));
        check_eq("n1_out", outs1, {32'h00000809, 32'h0, 32'h0, 32'h0});
      end
    end
    check_eq("n4_out", outs4, {32'h00000809, 32'h00000809, 32'h00000809, 32'h00000809});
    check_eq("n1_hold", outs1, {32'h00000809, 32'h0, 32'h0, 32'h0});

    // Thirteen-cycle cadence, x = 3..12.
    for (int k = 3; k <= 12; k++) begin
      run8("cad", {96'h0, 32'(k)}, xs_ref({96'h0, 32'(k)}, 8));
      tick();
      check_eq("cad_hold_fin", 128'(fin8), 128'(1));
      tick();
    end

    // Abort on edge 4 of a run.
    rst = 1'b0;
    S   = {96'h0, 32'd5};
    tick();
    rst = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check_eq("abort_pre_fin", 128'(fin8), 128'(0));
    end
    rst = 1'b0;
    S   = {96'h0, 32'd7};
    tick();
    check_eq("abort_fin", 128'(fin8), 128'(0));
    check_eq("abort_out", outs8, '0);
    run8("restart", {96'h0, 32'd7}, xs_ref({96'h0, 32'd7}, 8));

`ifdef ABT_ZERO_GUARD_EN
    exp_zero = xs_ref({32'h05491333, 32'h1F123BB5, 32'h159A55E5, 32'h075BCD15}, 8);
`else
    exp_zero = '0;
`endif
    run8("zero", '0, exp_zero);

    // Seed changes after release must not disturb a finished result.
    held = exp_zero;
    for (int c = 0; c < 20; c++) begin
      S = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      check_eq("hold_fin", 128'(fin8), 128'(1));
      check_eq("hold_out", outs8, held);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
